// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - radix-2 sequential multiply/divide unit feeding HI/LO
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               sq;
  logic               sr;
  logic               b_zero;
  logic [WIDTH-1:0]   a_orig;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  // MUL: {running high half, unconsumed multiplier bits}
  // DIV: {partial remainder, dividend bits shifting out / quotient bits shifting in}
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // Operand magnitudes for signed ops; |MIN| wraps to 2^(W-1), which is exact as unsigned.
  always_comb begin
    abs_a = (op[0] && a[WIDTH-1]) ? (~a + 1'b1) : a;
    abs_b = (op[0] && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // One shift-add multiply step: add multiplicand on LSB, then shift right with carry.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? ma : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // One restoring divide step: bring down next dividend bit, subtract if it fits.
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, mb};
    div_ge    = (div_shift >= {1'b0, mb});
    if (div_ge) begin
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign restoration applied on the FIX edge.
  always_comb begin
    prod_fix = sq ? (~acc + 1'b1) : acc;
    quo_fix  = sq ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = sr ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state <= S_CALC;
            cnt   <= '0;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          state     <= S_DONE;
          out_valid <= 1'b1;
        end
        default: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Operand capture at accept and datapath iteration during CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div <= 1'b0;
      sq     <= 1'b0;
      sr     <= 1'b0;
      b_zero <= 1'b0;
      a_orig <= '0;
      ma     <= '0;
      mb     <= '0;
      acc    <= '0;
    end else if (state == S_IDLE) begin
      if (in_valid) begin
        is_div <= op[1];
        sq     <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
        sr     <= op[0] & a[WIDTH-1];
        b_zero <= (b == '0);
        a_orig <= a;
        ma     <= abs_a;
        mb     <= abs_b;
        acc    <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
      end
    end else if (state == S_CALC) begin
      acc <= is_div ? div_next : mul_next;
    end
  end

  // Result registers: hold the previous result until FIX, div_zero clears at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else if (state == S_IDLE) begin
      if (in_valid) begin
        div_zero <= 1'b0;
      end
    end else if (state == S_FIX) begin
      if (is_div && b_zero) begin
        hi       <= a_orig;
        lo       <= {WIDTH{1'b1}};
        div_zero <= 1'b1;
      end else if (is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq against an arithmetic reference model
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_hi = '0;
  logic [31:0] prev_lo = '0;

  mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .hi(hi), .lo(lo), .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // MIPS MULT/MULTU/DIV/DIVU semantics from plain integer arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el, output logic ed);
    logic [63:0] p;
    longint sp;
    int sx, sy, q, r;
    ed = 1'b0;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'b00: begin
        p  = {32'b0, x} * {32'b0, y};
        eh = p[63:32];
        el = p[31:0];
      end
      2'b01: begin
        sp = longint'(sx) * longint'(sy);
        p  = sp;
        eh = p[63:32];
        el = p[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          eh = x;
          el = 32'hFFFF_FFFF;
          ed = 1'b1;
        end else if (o == 2'b10) begin
          el = x / y;
          eh = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          el = 32'h8000_0000;
          eh = 32'h0;
        end else begin
          q  = sx / sy;
          r  = sx % sy;
          el = q;
          eh = r;
        end
      end
    endcase
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int hold);
    logic [31:0] eh, el;
    logic ed;
    int lat;
    model(o, x, y, eh, el, ed);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      a = $urandom;
      b = $urandom;
      op = 2'($urandom);
      in_valid = 1'($urandom);
      chk("busy_during_calc", busy, 1'b1);
      chk("hi_held_until_fix", hi, prev_hi);
      chk("lo_held_until_fix", lo, prev_lo);
      chk("div_zero_cleared_at_accept", div_zero, 1'b0);
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, 33);
    chk("hi", hi, eh);
    chk("lo", lo, el);
    chk("div_zero", div_zero, ed);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_hi", hi, eh);
      chk("hold_lo", lo, el);
      chk("hold_div_zero", div_zero, ed);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_take", out_valid, 1'b0);
    chk("in_ready_after_take", in_ready, 1'b1);
    chk("hi_after_take", hi, eh);
    chk("lo_after_take", lo, el);
    prev_hi = eh;
    prev_lo = el;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_div_zero", div_zero, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("t1_hi_const", hi, 32'hFFFF_FFFE);
    chk("t1_lo_const", lo, 32'h0000_0001);
    do_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 0);
    chk("t2_lo_const", lo, 32'hFFFF_FFF1);
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1);
    chk("t2_hi_const", hi, 32'h4000_0000);
    do_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    chk("t3_lo_const", lo, 32'hFFFF_FFFD);
    do_op(2'b10, 32'h7, 32'h2, 0);
    do_op(2'b11, 32'h7, 32'hFFFF_FFFE, 0);
    chk("t3_hi_const", hi, 32'h1);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("t4_lo_const", lo, 32'h8000_0000);
    do_op(2'b10, 32'h5, 32'h0, 10);
    chk("t4_dz_const", div_zero, 1'b1);
    do_op(2'b11, 32'hFFFF_FFF7, 32'h0, 2);
    do_op(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    do_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 0);

    for (int n = 0; n < 24; n++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 9)) : $urandom);
      do_op(2'($urandom), ra, rb, $urandom_range(0, 3));
    end

    // Abort mid-CALC with an asynchronous reset.
    @(negedge clk);
    in_valid = 1'b1;
    op = 2'b00;
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    prev_hi = '0;
    prev_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1'b1);
    do_op(2'b00, 32'h3, 32'h4, 0);
    chk("t6_lo_const", lo, 32'hC);
    chk("t6_hi_const", hi, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
